// File: rtl/wb_stream_writer_ctrl_if.sv
// Wishbone B3 master-side bundle for the stream writer: request signals
// driven by the master, data and terminations returned by the slave.
interface wb_stream_writer_ctrl_if #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32
);
  logic [WB_AW-1:0]   wbm_adr_o;
  logic [WB_DW-1:0]   wbm_dat_o;
  logic [WB_DW/8-1:0] wbm_sel_o;
  logic               wbm_we_o;
  logic               wbm_cyc_o;
  logic               wbm_stb_o;
  logic [2:0]         wbm_cti_o;
  logic [1:0]         wbm_bte_o;
  logic [WB_DW-1:0]   wbm_dat_i;
  logic               wbm_ack_i;
  logic               wbm_err_i;
  logic               wbm_rty_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
           wbm_cti_o, wbm_bte_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
           wbm_cti_o, wbm_bte_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_rty_i
  );
endinterface

// File: rtl/wb_stream_writer_ctrl.sv
// Wishbone read-burst engine that copies a memory buffer into a stream FIFO.
// A transfer is started by a pulse on enable; it is split into incrementing
// bursts of at most burst_size words, and each burst is only issued once the
// FIFO has room for every word of it, so the FIFO can never overflow.
module wb_stream_writer_ctrl #(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 5
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  wb_stream_writer_ctrl_if.master wbm,
  output logic [WB_DW-1:0]     fifo_d_o,
  output logic                 fifo_wr_o,
  input  logic [FIFO_AW:0]     fifo_cnt_i,
  input  logic                 enable,
  input  logic [WB_AW-1:0]     start_adr,
  input  logic [WB_AW-1:0]     buf_size,
  input  logic [WB_AW-1:0]     burst_size,
  output logic                 busy,
  output logic [WB_DW-1:0]     tx_cnt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  // Common arithmetic width large enough for sizes, counts and FIFO space.
  localparam int CW0 = (WB_AW > WB_DW) ? WB_AW : WB_DW;
  localparam int CW  = (CW0 > FIFO_AW + 2) ? CW0 : FIFO_AW + 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    BURST      = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  state_e state_q, state_d;

  // Transfer parameters captured at start so the config block may change
  // its registers while a transfer runs.
  logic [WB_AW-1:0] start_q;
  logic [WB_AW-1:0] size_q;
  logic [WB_AW-1:0] burst_q;

  logic [WB_DW-1:0] tx_cnt_q;
  logic [CW-1:0]    beats_left_q;
  logic             cyc_q;
  cti_e             cti_q;
  logic             fifo_wr_q;
  logic [WB_DW-1:0] fifo_d_q;

  // FSM decisions
  logic load;    // accept a new transfer
  logic launch;  // open a burst
  logic beat;    // a word is acknowledged
  logic abort;   // bus error terminates the transfer

  logic [CW-1:0] remaining;
  logic [CW-1:0] max_burst;
  logic [CW-1:0] blen;
  logic [CW-1:0] occupied;
  logic [CW-1:0] space;
  logic          last_beat;
  logic          final_word;

  // Retry is not supported by this master; the input is deliberately unused.
  logic unused_rty;
  assign unused_rty = wbm.wbm_rty_i;

  // Burst sizing and FIFO headroom. A FIFO write still in flight is counted
  // as occupied, because the fill level input has not seen it yet.
  assign remaining  = CW'(size_q) - CW'(tx_cnt_q);
  assign max_burst  = (burst_q == '0) ? CW'(1) : CW'(burst_q);
  assign blen       = (remaining < max_burst) ? remaining : max_burst;
  assign occupied   = CW'(fifo_cnt_i) + CW'(fifo_wr_q);
  assign space      = (occupied >= CW'(DEPTH)) ? '0 : CW'(DEPTH) - occupied;
  assign last_beat  = (beats_left_q == CW'(1));
  assign final_word = (remaining == CW'(1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others; blocking here would create order races.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state and control decode.
  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    launch  = 1'b0;
    beat    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && (buf_size != '0)) begin
          load    = 1'b1;
          state_d = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (space >= blen) begin
          launch  = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        if (wbm.wbm_err_i) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (wbm.wbm_ack_i) begin
          beat = 1'b1;
          if (last_beat) state_d = final_word ? IDLE : WAIT_SPACE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latched transfer parameters and the fetched-word counter.
  // NOTE: these registers get an async reset even though they hold data,
  // because the visible outputs (address, tx_cnt) must read 0 in reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      start_q  <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      tx_cnt_q <= '0;
    end else if (load) begin
      start_q  <= start_adr;
      size_q   <= buf_size;
      burst_q  <= burst_size;
      tx_cnt_q <= '0;
    end else if (beat) begin
      tx_cnt_q <= tx_cnt_q + WB_DW'(1);
    end
  end

  // Bus cycle control: cyc/stb, cycle type and beats left in the burst.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cyc_q        <= 1'b0;
      cti_q        <= CTI_CLASSIC;
      beats_left_q <= '0;
    end else if (launch) begin
      cyc_q        <= 1'b1;
      cti_q        <= (blen == CW'(1)) ? CTI_EOB : CTI_INCR;
      beats_left_q <= blen;
    end else if (abort) begin
      cyc_q        <= 1'b0;
      cti_q        <= CTI_CLASSIC;
      beats_left_q <= '0;
    end else if (beat) begin
      beats_left_q <= beats_left_q - CW'(1);
      if (last_beat) begin
        cyc_q <= 1'b0;
        cti_q <= CTI_CLASSIC;
      end else if (beats_left_q == CW'(2)) begin
        cti_q <= CTI_EOB;
      end
    end
  end

  // Registered FIFO write path: one cycle after each acknowledged word.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      fifo_wr_q <= 1'b0;
      fifo_d_q  <= '0;
    end else begin
      fifo_wr_q <= beat;
      if (beat) fifo_d_q <= wbm.wbm_dat_i;
    end
  end

  // The address is derived from the word count, so it advances by one word
  // per acknowledge and wraps naturally at the top of the address space.
  assign wbm.wbm_adr_o = start_q + (WB_AW'(tx_cnt_q) << 2);
  assign wbm.wbm_dat_o = '0;
  assign wbm.wbm_sel_o = '1;
  assign wbm.wbm_we_o  = 1'b0;
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_cti_o = cti_q;
  assign wbm.wbm_bte_o = 2'b00;

  assign fifo_wr_o = fifo_wr_q;
  assign fifo_d_o  = fifo_d_q;
  // busy follows the state directly so it drops in the cycle IDLE is entered.
  assign busy      = (state_q != IDLE);
  assign tx_cnt    = tx_cnt_q;

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Self-checking bench for wb_stream_writer_ctrl: a Wishbone slave model
// answers reads with address-derived data; expected bus beats and FIFO words
// are queued when a transfer is started and popped as the DUT produces them.
module tb_wb_stream_writer_ctrl;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int FAW = 5;

  logic          wb_clk_i  = 1'b0;
  logic          wb_rst_ni = 1'b0;
  logic [DW-1:0] fifo_d;
  logic          fifo_wr;
  logic [FAW:0]  fifo_cnt   = '0;
  logic          enable     = 1'b0;
  logic [AW-1:0] start_adr  = '0;
  logic [AW-1:0] buf_size   = '0;
  logic [AW-1:0] burst_size = '0;
  logic          busy;
  logic [DW-1:0] tx_cnt;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_stream_writer_ctrl_if #(.WB_AW(AW), .WB_DW(DW)) wb ();

  wb_stream_writer_ctrl #(.WB_AW(AW), .WB_DW(DW), .FIFO_AW(FAW)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .wbm        (wb.master),
    .fifo_d_o   (fifo_d),
    .fifo_wr_o  (fifo_wr),
    .fifo_cnt_i (fifo_cnt),
    .enable     (enable),
    .start_adr  (start_adr),
    .buf_size   (buf_size),
    .burst_size (burst_size),
    .busy       (busy),
    .tx_cnt     (tx_cnt)
  );

  // Slave model
  logic ack_en = 1'b1;
  int   err_at = 0;   // 1-based beat that gets an error, 0 = never
  int   beat_idx = 0;

  function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
  endfunction

  assign wb.wbm_err_i = wb.wbm_cyc_o & wb.wbm_stb_o & (err_at == beat_idx + 1);
  assign wb.wbm_ack_i = wb.wbm_cyc_o & wb.wbm_stb_o & ack_en & ~wb.wbm_err_i;
  assign wb.wbm_rty_i = 1'b0;
  assign wb.wbm_dat_i = slave_data(wb.wbm_adr_o);

  always @(posedge wb_clk_i) begin
    if (enable && !busy)    beat_idx <= 0;
    else if (wb.wbm_ack_i)  beat_idx <= beat_idx + 1;
  end

  // Scoreboard
  typedef struct packed {
    logic [AW-1:0] adr;
    logic [2:0]    cti;
  } beat_t;

  typedef struct {
    string         name;
    logic [AW-1:0] start;
    logic [AW-1:0] size;
    logic [AW-1:0] burst;
    logic [DW-1:0] exp_tx;
    int            exp_wr;
  } vec_t;

  beat_t         exp_beats[$];
  logic [DW-1:0] exp_data[$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int falls  = 0;
  logic busy_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected beats of a transfer, truncated to the first max_beats words.
  task automatic plan(input logic [AW-1:0] s, input logic [AW-1:0] sz,
                      input logic [AW-1:0] bs, input int max_beats);
    int unsigned b, done, len, n;
    logic [AW-1:0] a;
    beat_t e;
    b    = (bs == 0) ? 1 : int'(bs);
    done = 0;
    n    = 0;
    while (done < sz) begin
      len = ((sz - done) < b) ? int'(sz - done) : b;
      for (int k = 0; k < int'(len); k++) begin
        a = s + 32'(4 * (done + k));
        if (n < max_beats) begin
          e.adr = a;
          e.cti = (k == int'(len) - 1) ? 3'b111 : 3'b010;
          exp_beats.push_back(e);
          exp_data.push_back(slave_data(a));
        end
        n++;
      end
      done += len;
    end
  endtask

  // Advance to the next falling edge and score whatever the DUT produced.
  task automatic tick();
    beat_t e;
    logic [DW-1:0] d;
    @(negedge wb_clk_i);
    if (wb.wbm_cyc_o && wb.wbm_stb_o && wb.wbm_ack_i) begin
      if (exp_beats.size() == 0) check("beat_expected", 64'(exp_beats.size()), 1);
      else begin
        e = exp_beats.pop_front();
        check("beat_adr", wb.wbm_adr_o, e.adr);
        check("beat_cti", wb.wbm_cti_o, e.cti);
      end
    end
    if (fifo_wr) begin
      wr_cnt++;
      if (exp_data.size() == 0) check("fifo_wr_expected", 64'(exp_data.size()), 1);
      else begin
        d = exp_data.pop_front();
        check("fifo_d", fifo_d, d);
      end
    end
    if (busy_prev && !busy) falls++;
    busy_prev = busy;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    check({name, "_done"}, busy, 0);
    check({name, "_cyc_low"}, wb.wbm_cyc_o, 0);
  endtask

  task automatic run_case(input vec_t v, input bit reen);
    int n;
    plan(v.start, v.size, v.burst, 1 << 30);
    wr_cnt = 0;
    falls  = 0;
    start_adr = v.start; buf_size = v.size; burst_size = v.burst; enable = 1'b1;
    tick();
    enable = 1'b0;
    check({v.name, "_busy_rise"}, busy, 1);
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
      if (reen && n == 3) begin
        start_adr = 32'h9000; buf_size = 32'd3; burst_size = 32'd1; enable = 1'b1;
      end else begin
        enable = 1'b0;
      end
    end
    enable = 1'b0;
    check({v.name, "_done"}, busy, 0);
    tick();
    tick();
    check({v.name, "_tx_cnt"}, tx_cnt, v.exp_tx);
    check({v.name, "_writes"}, 64'(wr_cnt), 64'(v.exp_wr));
    check({v.name, "_busy_falls"}, 64'(falls), 1);
    check({v.name, "_beats_left"}, 64'(exp_beats.size()), 0);
    check({v.name, "_data_left"}, 64'(exp_data.size()), 0);
  endtask

  vec_t vecs[4];
  vec_t v;

  initial begin
    vecs[0] = '{"two_bursts",   32'h100,  32'd8, 32'd4,  32'd8, 8};
    vecs[1] = '{"tail_single",  32'h2000, 32'd5, 32'd4,  32'd5, 5};
    vecs[2] = '{"burst_zero",   32'h40,   32'd3, 32'd0,  32'd3, 3};
    vecs[3] = '{"burst_gt_buf", 32'h800,  32'd6, 32'd16, 32'd6, 6};

    // Reset state
    tick();
    tick();
    check("rst_cyc",    wb.wbm_cyc_o, 0);
    check("rst_stb",    wb.wbm_stb_o, 0);
    check("rst_adr",    wb.wbm_adr_o, 0);
    check("rst_cti",    wb.wbm_cti_o, 0);
    check("rst_fifo_wr", fifo_wr, 0);
    check("rst_fifo_d", fifo_d, 0);
    check("rst_busy",   busy, 0);
    check("rst_tx_cnt", tx_cnt, 0);
    check("const_we",   wb.wbm_we_o, 0);
    check("const_sel",  wb.wbm_sel_o, 4'hF);
    check("const_bte",  wb.wbm_bte_o, 0);
    check("const_dat",  wb.wbm_dat_o, 0);
    wb_rst_ni = 1'b1;
    tick();

    // Table-driven transfers
    for (int i = 0; i < 4; i++) run_case(vecs[i], 1'b0);

    // Enable during busy is ignored
    v = '{"reenable", 32'h500, 32'd6, 32'd2, 32'd6, 6};
    run_case(v, 1'b1);

    // Waiting for FIFO space: 2 free words cannot hold a 4-word burst
    fifo_cnt = 6'd30;
    plan(32'h300, 32'd4, 32'd4, 1 << 30);
    wr_cnt = 0;
    start_adr = 32'h300; buf_size = 32'd4; burst_size = 32'd4; enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ws_cyc_low", wb.wbm_cyc_o, 0);
    end
    check("ws_busy", busy, 1);
    check("ws_cti", wb.wbm_cti_o, 0);
    check("ws_no_writes", 64'(wr_cnt), 0);
    fifo_cnt = 6'd28;
    tick();
    check("ws_cyc_start", wb.wbm_cyc_o, 1);
    wait_idle("ws");
    tick();
    tick();
    check("ws_tx_cnt", tx_cnt, 4);
    check("ws_writes", 64'(wr_cnt), 4);
    fifo_cnt = '0;

    // Bus error on beat 3 of the first burst
    err_at = 3;
    plan(32'h1000, 32'd8, 32'd4, 2);
    wr_cnt = 0;
    start_adr = 32'h1000; buf_size = 32'd8; burst_size = 32'd4; enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_idle("err");
    tick();
    tick();
    err_at = 0;
    check("err_tx_cnt", tx_cnt, 2);
    check("err_writes", 64'(wr_cnt), 2);
    check("err_beats_left", 64'(exp_beats.size()), 0);

    // Zero-length enable has no effect; tx_cnt keeps the last value
    start_adr = 32'h55; buf_size = 32'd0; burst_size = 32'd4; enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    tick();
    check("zero_busy", busy, 0);
    check("zero_cyc", wb.wbm_cyc_o, 0);
    check("zero_tx_hold", tx_cnt, 2);

    // Asynchronous reset with the slave stalled mid-burst
    ack_en = 1'b0;
    wr_cnt = 0;
    start_adr = 32'h700; buf_size = 32'd4; burst_size = 32'd4; enable = 1'b1;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 20 && !wb.wbm_cyc_o; i++) tick();
    check("stall_cyc_high", wb.wbm_cyc_o, 1);
    #2;
    wb_rst_ni = 1'b0;
    #1;
    check("arst_cyc", wb.wbm_cyc_o, 0);
    check("arst_stb", wb.wbm_stb_o, 0);
    check("arst_busy", busy, 0);
    tick();
    wb_rst_ni = 1'b1;
    ack_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("arst_no_cyc", wb.wbm_cyc_o, 0);
    check("arst_no_writes", 64'(wr_cnt), 0);
    check("arst_tx_cnt", tx_cnt, 0);

    // Address wrap at the top of the address space
    v = '{"wrap", 32'hFFFF_FFF8, 32'd4, 32'd4, 32'd4, 4};
    run_case(v, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wb_stream_writer_ctrl.md
WB_STREAM_WRITER_CTRL -- requirements
Module: wb_stream_writer_ctrl

Interface
REQ-001 SHALL have parameters: WB_AW, default 32, Wishbone address width; WB_DW, default 32, data width; FIFO_AW, default 5, downstream FIFO address width (depth 2**FIFO_AW words).
REQ-002 SHALL have ports, one per line:
  wb_clk_i  in  1  clock, all state on rising edge
  wb_rst_ni  in  1  reset, asynchronous, active-low
  wbm_adr_o  out  WB_AW  byte address, word aligned
  wbm_dat_o  out  WB_DW  write data, constant 0
  wbm_sel_o  out  WB_DW/8  byte selects, constant all ones
  wbm_we_o  out  1  constant 0 (read-only master)
  wbm_cyc_o / wbm_stb_o  out  1  cycle / strobe
  wbm_cti_o  out  3  cycle type identifier
  wbm_bte_o  out  2  constant 2'b00 (linear)
  wbm_dat_i  in  WB_DW  read data
  wbm_ack_i / wbm_err_i / wbm_rty_i  in  1  slave termination; rty ignored
  fifo_d_o  out  WB_DW  data to stream FIFO
  fifo_wr_o  out  1  FIFO write strobe
  fifo_cnt_i  in  FIFO_AW+1  current FIFO fill level, words
  enable  in  1  start pulse from config block
  start_adr  in  WB_AW  buffer start byte address
  buf_size  in  WB_AW  transfer length, words
  burst_size  in  WB_AW  max words per burst
  busy  out  1  transfer in progress
  tx_cnt  out  WB_DW  words fetched in current/last transfer

Function
REQ-003 SHALL implement FSM states IDLE, WAIT_SPACE, BURST.
REQ-004 IDLE: on enable=1 with buf_size!=0, SHALL latch start_adr, buf_size, burst_size, clear tx_cnt to 0, set busy=1 and enter WAIT_SPACE next cycle; enable with buf_size=0 SHALL have no effect.
REQ-005 enable asserted while busy=1 SHALL be ignored; latched parameters SHALL not change mid-transfer.
REQ-006 Burst length SHALL be min(max(burst_size,1), remaining) with remaining = latched buf_size - tx_cnt.
REQ-007 WAIT_SPACE: SHALL enter BURST only when (2**FIFO_AW - fifo_cnt_i) >= burst length; otherwise wait indefinitely.
REQ-008 On entering BURST SHALL assert wbm_cyc_o=wbm_stb_o=1 with wbm_adr_o = latched start_adr + 4*tx_cnt, modulo 2**WB_AW.
REQ-009 wbm_cti_o SHALL be 3'b010 on every beat except the final beat of a burst, which SHALL be 3'b111; single-beat bursts SHALL use 3'b111; 3'b000 outside BURST.
REQ-010 Each cycle with wbm_ack_i=1 in BURST SHALL: advance wbm_adr_o by 4, increment tx_cnt by 1, and produce fifo_wr_o=1 with fifo_d_o = that wbm_dat_i on the following cycle (1-cycle registered latency).
REQ-011 After the final-beat ack, cyc/stb SHALL deassert the next cycle; SHALL go to IDLE with busy=0 if remaining=0, else to WAIT_SPACE.
REQ-012 wbm_err_i=1 in BURST SHALL abort: no FIFO write for that beat, cyc/stb deasserted next cycle, state IDLE, busy=0, tx_cnt holds words already fetched.
REQ-013 fifo_wr_o SHALL never be asserted when the FIFO lacks space reserved per REQ-007.
REQ-014 busy SHALL fall in the same cycle the FSM enters IDLE, so the config block sees exactly one falling edge per transfer.
REQ-015 tx_cnt SHALL retain its final value in IDLE until the next accepted enable.

Reset
REQ-016 While wb_rst_ni=0, asynchronously: state IDLE, wbm_cyc_o=wbm_stb_o=0, wbm_adr_o=0, wbm_cti_o=0, fifo_wr_o=0, fifo_d_o=0, busy=0, tx_cnt=0, latched parameters 0.
REQ-017 Reset asserted mid-burst SHALL drop cyc/stb immediately; no further FIFO writes after release until a new enable.

Verification
REQ-018 start_adr=0x100, buf_size=8, burst_size=4, FIFO empty, ack every cycle -> two bursts at 0x100..0x10C, 0x110..0x11C, cti 010,010,010,111 each; 8 fifo_wr; tx_cnt=8; busy falls once.
REQ-019 buf_size=5, burst_size=4 -> bursts of 4 then 1 word; second burst cti=111 single beat; tx_cnt=5.
REQ-020 FIFO_AW=5, fifo_cnt_i=30, burst_size=4 -> stays in WAIT_SPACE, cyc=0; drop fifo_cnt_i to 28 -> burst starts next cycle.
REQ-021 wbm_err_i on beat 3 of first burst (buf_size=8) -> 2 FIFO writes, busy=0, tx_cnt=2, cyc low next cycle.
REQ-022 enable pulse with buf_size=0 -> busy stays 0, no cycle; enable pulse during busy -> transfer unaffected.
REQ-023 wb_rst_ni low mid-burst (slave ack stalled) -> cyc/stb/busy low without clock edge; start_adr=0xFFFFFFF8, buf_size=4 after reset -> addresses wrap 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
